// File: rtl/apple_spawner.sv
`default_nettype none
// ============================================================================
//  Module   : apple_spawner
//  Purpose  : Places the apple for the snake game on a random free grid cell.
//             A free-running 16-bit LFSR proposes candidate cells. An accepted
//             candidate is then shown "invisibly" for one whole frame. The
//             external overlap detector reports whether the apple area hits
//             any snake segment during that frame. A clean frame makes the
//             apple visible. A collision throws the candidate away and draws
//             a new one. The head reaching the apple on a frame boundary
//             counts as an eat.
//
//  Ports    : clk          - single clock, rising edge
//             rst          - asynchronous active-high reset
//             frame_tick   - one-cycle pulse at the start of vertical blank
//             head_x/y     - snake head cell top-left pixel (grid aligned)
//             overlap_pix  - ungated apple area and snake body both active
//             x_start/y_start - apple top-left pixel, to the apple renderer
//             apple_valid  - apple placed and must be displayed
//             eaten        - one-cycle registered pulse on an eat
//             score        - apples eaten, saturating at 255
//
//  Config   : APPLE_SCORE_EN - when defined, builds the saturating score
//             counter. When undefined, score is tied to zero and no counter
//             flops exist.
//
//  Revision : 1.0 - initial release
// ============================================================================
module apple_spawner #(
    parameter int BIT    = 10,   // width of all pixel coordinates
    parameter int SIZE   = 20,   // apple / grid cell edge in pixels
    parameter int GRID_W = 32,   // playfield cells horizontally
    parameter int GRID_H = 24    // playfield cells vertically
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           frame_tick,
    input  logic [BIT-1:0] head_x,
    input  logic [BIT-1:0] head_y,
    input  logic           overlap_pix,
    output logic [BIT-1:0] x_start,
    output logic [BIT-1:0] y_start,
    output logic           apple_valid,
    output logic           eaten,
    output logic [7:0]     score
);

    localparam logic [15:0] c_LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        S_PLACE  = 2'd0,   // draw candidates until one lies on the grid
        S_SYNC   = 2'd1,   // align the probe window to a frame boundary
        S_PROBE  = 2'd2,   // one full frame of collision checking
        S_ACTIVE = 2'd3    // apple visible, waiting for the head
    } state_t;

    state_t         r_state;
    logic [15:0]    r_lfsr;
    logic [BIT-1:0] r_x;
    logic [BIT-1:0] r_y;
    logic           r_valid;
    logic           r_eaten;

    logic [4:0]     w_cx;
    logic [4:0]     w_cy;
    logic           w_cand_ok;
    logic [BIT-1:0] w_x_pix;
    logic [BIT-1:0] w_y_pix;
    logic           w_lfsr_fb;
    logic           w_head_hit;
    logic           w_eat;

    // ------------------------------------------------------------------------
    // Fibonacci LFSR, taps 16,14,13,11. It runs in every state. The number of
    // cycles spent in SYNC/PROBE/ACTIVE then adds to the randomness of the
    // next draw.
    // ------------------------------------------------------------------------
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= c_LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    // ------------------------------------------------------------------------
    // Candidate cell. Out-of-range draws are rejected. PLACE simply retries on
    // the next cycle with the next LFSR value.
    // ------------------------------------------------------------------------
    assign w_cx      = r_lfsr[4:0];
    assign w_cy      = r_lfsr[9:5];
    assign w_cand_ok = (32'(w_cx) < GRID_W) && (32'(w_cy) < GRID_H);
    assign w_x_pix   = BIT'(32'(w_cx) * SIZE);
    assign w_y_pix   = BIT'(32'(w_cy) * SIZE);

    // An eat is only sampled on a frame boundary. The head position is then
    // stable for the whole frame, so a mid-frame match is not an eat.
    assign w_head_hit = (head_x == r_x) && (head_y == r_y);
    assign w_eat      = (r_state == S_ACTIVE) && frame_tick && w_head_hit;

    // ------------------------------------------------------------------------
    // Placement FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_PLACE;
            r_x     <= '0;
            r_y     <= '0;
            r_valid <= 1'b0;
            r_eaten <= 1'b0;
        end else begin
            r_eaten <= 1'b0;
            case (r_state)
                S_PLACE: begin
                    // frame_tick is deliberately ignored here
                    if (w_cand_ok) begin
                        r_x     <= w_x_pix;
                        r_y     <= w_y_pix;
                        r_state <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (frame_tick) begin
                        r_state <= S_PROBE;
                    end
                end
                S_PROBE: begin
                    // A collision on the very last pixel cycle must still
                    // reject the cell, so overlap takes priority over the tick
                    if (overlap_pix) begin
                        r_state <= S_PLACE;
                    end else if (frame_tick) begin
                        r_state <= S_ACTIVE;
                        r_valid <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (w_eat) begin
                        r_eaten <= 1'b1;
                        r_valid <= 1'b0;
                        r_state <= S_PLACE;
                    end
                end
                default: begin
                    r_state <= S_PLACE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign x_start     = r_x;
    assign y_start     = r_y;
    assign apple_valid = r_valid;
    assign eaten       = r_eaten;

    // ------------------------------------------------------------------------
    // Optional score counter
    // ------------------------------------------------------------------------
`ifdef APPLE_SCORE_EN
    logic [7:0] r_score;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_score <= 8'd0;
        end else if (w_eat && (r_score != 8'hFF)) begin
            r_score <= r_score + 8'd1;
        end
    end

    assign score = r_score;
`else
    assign score = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_apple_spawner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apple_spawner
//  Purpose  : Directed self-checking bench for apple_spawner. Apple positions
//             are predicted from a reference LFSR that starts from the same
//             seed and steps on the same clock edges.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apple_spawner;

    localparam int BIT    = 10;
    localparam int SIZE   = 20;
    localparam int GRID_W = 32;
    localparam int GRID_H = 24;
`ifdef APPLE_SCORE_EN
    localparam int SCORE_ON = 1;
`else
    localparam int SCORE_ON = 0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           frame_tick;
    logic [BIT-1:0] head_x;
    logic [BIT-1:0] head_y;
    logic           overlap_pix;
    logic [BIT-1:0] x_start;
    logic [BIT-1:0] y_start;
    logic           apple_valid;
    logic           eaten;
    logic [7:0]     score;

    apple_spawner #(
        .BIT    (BIT),
        .SIZE   (SIZE),
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .head_x      (head_x),
        .head_y      (head_y),
        .overlap_pix (overlap_pix),
        .x_start     (x_start),
        .y_start     (y_start),
        .apple_valid (apple_valid),
        .eaten       (eaten),
        .score       (score)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int eat_seen = 0;

    logic [BIT-1:0] exp_x;
    logic [BIT-1:0] exp_y;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference LFSR: taps 16,14,13,11, seed ACE1, steps every clock edge
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    logic [15:0] m_lfsr;
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= lfsr_step(m_lfsr);
    end

    // Call at #1 after the edge that moved the DUT into PLACE. m_lfsr then
    // holds the value the DUT examines on its next edge.
    task automatic predict();
        logic [15:0] v;
        v = m_lfsr;
        for (int k = 0; k < 1000; k++) begin
            if (int'(v[4:0]) < GRID_W && int'(v[9:5]) < GRID_H) break;
            v = lfsr_step(v);
        end
        exp_x = BIT'(int'(v[4:0]) * SIZE);
        exp_y = BIT'(int'(v[9:5]) * SIZE);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (eaten === 1'b1) eat_seen++;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    int bad_valid;
    int bad_pos;
    int max_score;
    int score_at_255;

    initial begin
        rst         = 1'b1;
        frame_tick  = 1'b0;
        overlap_pix = 1'b0;
        head_x      = '0;
        head_y      = '0;
        repeat (3) tick();

        check_eq("rst_x",     32'(x_start),     0);
        check_eq("rst_y",     32'(y_start),     0);
        check_eq("rst_valid", 32'(apple_valid), 0);
        check_eq("rst_eaten", 32'(eaten),       0);
        check_eq("rst_score", 32'(score),       0);

        // Seed ACE1 gives cx=1, cy=7 on the first edge after release
        rst = 1'b0;
        tick();
        check_eq("place0_x",     32'(x_start),     20);
        check_eq("place0_y",     32'(y_start),     140);
        check_eq("place0_valid", 32'(apple_valid), 0);
        check_eq("place0_grid",  32'((x_start % SIZE == 0) && (x_start <= 620) &&
                                     (y_start % SIZE == 0) && (y_start <= 460)), 1);

        frame();
        repeat (5) tick();
        check_eq("probe_valid", 32'(apple_valid), 0);
        frame();
        check_eq("active_valid", 32'(apple_valid), 1);

        // Head on the apple without a frame boundary: nothing happens
        head_x   = 10'd20;
        head_y   = 10'd140;
        eat_seen = 0;
        repeat (1000) tick();
        check_eq("nohit_eaten", 32'(eat_seen),    0);
        check_eq("nohit_score", 32'(score),       0);
        check_eq("nohit_valid", 32'(apple_valid), 1);

        // Eat on the frame boundary
        frame();
        check_eq("eat_pulse", 32'(eaten),       1);
        check_eq("eat_score", 32'(score),       32'(SCORE_ON));
        check_eq("eat_valid", 32'(apple_valid), 0);
        predict();
        tick();
        check_eq("eat_one_cycle", 32'(eaten),       0);
        check_eq("eat_valid_nxt", 32'(apple_valid), 0);
        repeat (30) tick();
        check_eq("place1_x", 32'(x_start), 32'(exp_x));
        check_eq("place1_y", 32'(y_start), 32'(exp_y));

        // Overlap mid-PROBE rejects the cell and draws a new one
        frame();
        repeat (3) tick();
        overlap_pix = 1'b1;
        tick();
        overlap_pix = 1'b0;
        predict();
        check_eq("ovl_valid", 32'(apple_valid), 0);
        repeat (30) tick();
        check_eq("ovl_x",      32'(x_start),     32'(exp_x));
        check_eq("ovl_y",      32'(y_start),     32'(exp_y));
        check_eq("ovl_valid2", 32'(apple_valid), 0);
        frame();
        check_eq("ovl_sync", 32'(apple_valid), 0);
        frame();
        check_eq("ovl_active", 32'(apple_valid), 1);

        // Eat, re-place, then overlap and frame_tick in the same PROBE cycle
        head_x = exp_x;
        head_y = exp_y;
        frame();
        check_eq("eat2_pulse", 32'(eaten), 1);
        predict();
        repeat (30) tick();
        frame();
        repeat (3) tick();
        frame_tick  = 1'b1;
        overlap_pix = 1'b1;
        tick();
        frame_tick  = 1'b0;
        overlap_pix = 1'b0;
        predict();
        check_eq("coin_valid", 32'(apple_valid), 0);
        repeat (30) tick();
        check_eq("coin_x", 32'(x_start), 32'(exp_x));
        check_eq("coin_y", 32'(y_start), 32'(exp_y));
        frame();
        check_eq("coin_sync", 32'(apple_valid), 0);
        frame();
        check_eq("coin_active", 32'(apple_valid), 1);
        check_eq("score_two", 32'(score), 32'(2 * SCORE_ON));

        // Reset asserted mid-PROBE aborts at once
        head_x = exp_x;
        head_y = exp_y;
        frame();
        predict();
        repeat (30) tick();
        frame();
        repeat (2) tick();
        rst = 1'b1;
        #1;
        check_eq("mid_rst_x",     32'(x_start),     0);
        check_eq("mid_rst_valid", 32'(apple_valid), 0);
        check_eq("mid_rst_score", 32'(score),       0);
        tick();
        rst = 1'b0;
        tick();
        check_eq("rerst_x", 32'(x_start), 20);
        check_eq("rerst_y", 32'(y_start), 140);
        exp_x = 10'd20;
        exp_y = 10'd140;

        // 256 eats: score saturates with the counter, stays 0 without it
        bad_valid    = 0;
        bad_pos      = 0;
        max_score    = 0;
        score_at_255 = -1;
        eat_seen     = 0;
        for (int i = 0; i < 256; i++) begin
            if (x_start !== exp_x || y_start !== exp_y) bad_pos++;
            frame();
            frame();
            if (apple_valid !== 1'b1) bad_valid++;
            head_x = exp_x;
            head_y = exp_y;
            frame();
            if (int'(score) > max_score) max_score = int'(score);
            if (i == 254) score_at_255 = int'(score);
            predict();
            repeat (30) tick();
        end
        check_eq("loop_valid",   32'(bad_valid),    0);
        check_eq("loop_pos",     32'(bad_pos),      0);
        check_eq("loop_eats",    32'(eat_seen),     256);
        check_eq("score_255",    32'(score_at_255), 32'(255 * SCORE_ON));
        check_eq("score_sat",    32'(score),        32'(255 * SCORE_ON));
        check_eq("score_max",    32'(max_score),    32'(255 * SCORE_ON));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apple_spawner.md
APPLE_SPAWNER -- requirements
Module: apple_spawner

Interface
REQ-001 The block SHALL have parameter BIT, default 10, meaning the width of all pixel coordinates.
REQ-002 The block SHALL have parameter SIZE, default 20, meaning the apple/grid cell edge in pixels.
REQ-003 The block SHALL have parameter GRID_W, default 32, meaning the number of playfield cells horizontally.
REQ-004 The block SHALL have parameter GRID_H, default 24, meaning the number of playfield cells vertically.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; every register is clocked on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-007 The block SHALL have port frame_tick, input, 1 bit: a one-cycle pulse at the start of each vertical blank.
REQ-008 The block SHALL have port head_x, input, BIT bits: the snake head cell's top-left pixel x, grid-aligned.
REQ-009 The block SHALL have port head_y, input, BIT bits: the snake head cell's top-left pixel y, grid-aligned.
REQ-010 The block SHALL have port overlap_pix, input, 1 bit: high on a pixel where the ungated apple area and any snake segment are both active.
REQ-011 The block SHALL have port x_start, output, BIT bits: the apple top-left x, to the apple renderer.
REQ-012 The block SHALL have port y_start, output, BIT bits: the apple top-left y, to the apple renderer.
REQ-013 The block SHALL have port apple_valid, output, 1 bit: high when the apple is placed and must be displayed.
REQ-014 The block SHALL have port eaten, output, 1 bit: a one-cycle registered pulse when the head reaches the apple.
REQ-015 The block SHALL have port score, output, 8 bits: the apples-eaten count.

Function
REQ-016 The block SHALL contain a 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every clock cycle in all states.
REQ-017 The FSM SHALL have exactly four states: PLACE, SYNC, PROBE and ACTIVE.
REQ-018 In PLACE, the block SHALL form the candidate cx=lfsr[4:0], cy=lfsr[9:5] each cycle, rejecting cx>=GRID_W or cy>=GRID_H and retrying on the next cycle.
REQ-019 On acceptance, the block SHALL register x_start=cx*SIZE and y_start=cy*SIZE (truncated to BIT bits) and go to SYNC.
REQ-020 In SYNC, the block SHALL wait for frame_tick, then go to PROBE.
REQ-021 In PROBE, the block SHALL watch overlap_pix for one full frame: any overlap_pix=1 goes to PLACE; frame_tick with no overlap seen goes to ACTIVE.
REQ-022 If overlap_pix and frame_tick are high in the same PROBE cycle, the overlap SHALL win and the next state SHALL be PLACE.
REQ-023 apple_valid SHALL be 1 only in ACTIVE; x_start and y_start SHALL remain stable outside PLACE.
REQ-024 In ACTIVE, on frame_tick with head_x==x_start and head_y==y_start, the block SHALL assert eaten for exactly the next cycle, increment score and go to PLACE.
REQ-025 score SHALL saturate at 255.
REQ-026 A head match without frame_tick SHALL be ignored.
REQ-027 frame_tick in PLACE SHALL be ignored.

Reset
REQ-028 While rst=1, the block SHALL hold state=PLACE, lfsr=16'hACE1, x_start=0, y_start=0, apple_valid=0, eaten=0 and score=0.
REQ-029 Assertion of rst in any state, including mid-PROBE, SHALL abort immediately; the first active edge after release SHALL evaluate PLACE.

Configuration
REQ-030 With macro APPLE_SCORE_EN defined, the block SHALL implement the score counter as specified above.
REQ-031 Without APPLE_SCORE_EN, the block SHALL drive score constant 8'd0, implement no counter flops, and leave all other behaviour unchanged.

Verification
REQ-032 The bench SHALL check: release reset, overlap_pix=0, two frame_ticks -> apple_valid=1 with x_start a multiple of 20 <=620 and y_start a multiple of 20 <=460.
REQ-033 The bench SHALL check: overlap_pix=1 pulsed mid-PROBE -> apple_valid stays 0, the FSM returns to PLACE and a new position is drawn.
REQ-034 The bench SHALL check: in ACTIVE, head equals apple and frame_tick -> eaten=1 for one cycle, score 0->1, apple_valid=0 next cycle.
REQ-035 The bench SHALL check: head equals apple with no frame_tick for 1000 cycles -> no eaten and score unchanged.
REQ-036 The bench SHALL check: overlap_pix and frame_tick coincide in PROBE -> the next state is PLACE, not ACTIVE.
REQ-037 The bench SHALL check: 256 eats with APPLE_SCORE_EN -> score=255; the same run without the macro -> score=0 throughout.
